// File: rtl/mc_seq.sv
// rtl/mc_seq.sv - multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with memory handshakes
// Optional MC_SEQ_INSTRET_EN adds a 32-bit retired-instruction counter on instret.
module mc_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  inst_op,
    input  logic        dec_rf_we,
    input  logic        dec_dram_we,
    input  logic        dec_npc_op,
    output logic        imem_req,
    input  logic        imem_ack,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ack,
    output logic        ir_we,
    output logic        pc_we,
    output logic        npc_sel,
    output logic        rf_we,
    output logic        halted,
    output logic        err_timeout,
    output logic [2:0]  state,
    output logic [31:0] instret
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam int CW = 16;
    // Halt decision is taken in the cycle whose count is TIMEOUT-1, so the
    // counter would read TIMEOUT on the edge that enters HALT.
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] wait_cnt;
    logic          err_q;
    logic          timeout_set;
    logic          wd_expire;

    assign wd_expire = (TIMEOUT != 0) && (wait_cnt == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        npc_sel     = 1'b0;
        rf_we       = 1'b0;
        halted      = 1'b0;
        timeout_set = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    imem_req = 1'b1;
                    if (imem_ack) begin
                        ir_we   = 1'b1;
                        state_d = S_DECODE;
                    end else if (wd_expire) begin
                        timeout_set = 1'b1;
                        state_d     = S_HALT;
                    end
                end
                S_DECODE: state_d = S_EXEC;
                S_EXEC: begin
                    case (inst_op)
                        OP_LOAD, OP_STORE: state_d = S_MEM;
                        OP_BRANCH: begin
                            pc_we   = 1'b1;
                            npc_sel = dec_npc_op;
                            state_d = S_FETCH;
                        end
                        OP_ALU, OP_ALUI, OP_LUI, OP_JAL, OP_JALR: state_d = S_WB;
                        default: state_d = S_HALT;
                    endcase
                end
                S_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = dec_dram_we;
                    if (dmem_ack) begin
                        if (inst_op == OP_STORE) begin
                            pc_we   = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end else if (wd_expire) begin
                        timeout_set = 1'b1;
                        state_d     = S_HALT;
                    end
                end
                S_WB: begin
                    rf_we   = dec_rf_we;
                    pc_we   = 1'b1;
                    npc_sel = dec_npc_op;
                    state_d = S_FETCH;
                end
                S_HALT: halted = 1'b1;
                default: state_d = S_HALT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (timeout_set) begin
                err_q <= 1'b1;
            end
            // Any state change (entry to FETCH or MEM included) restarts the wait count.
            if (state_d != state_q) begin
                wait_cnt <= '0;
            end else if ((imem_req && !imem_ack) || (dmem_req && !dmem_ack)) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    assign state       = rst ? 3'd0 : state_q;
    assign err_timeout = err_q & ~rst;

`ifdef MC_SEQ_INSTRET_EN
    logic [31:0] instret_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            instret_q <= '0;
        end else if (pc_we) begin
            instret_q <= instret_q + 32'd1;
        end
    end

    assign instret = rst ? 32'd0 : instret_q;
`else
    assign instret = 32'd0;
`endif

endmodule

// File: doc/mc_seq.md
# mc_seq

Multi-cycle sequencer for the miniRV core. It steps each instruction through fetch, decode, execute, memory and write-back. It gates the single-cycle decoder's `rf_we`, `dram_we` and `npc_op` so they take effect only in the correct phase. It also runs req/ack handshakes with instruction and data memory, so the existing datapath works with multi-cycle (wait-state) memories.

## Interface
Parameters:
- `TIMEOUT`, default 255: maximum cycles a memory request may wait for ack before the sequencer halts. 0 disables the watchdog.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset; synchronous, active-high.
- `inst_op`  in  7  `inst[6:0]` of the currently latched IR.
- `dec_rf_we`  in  1  register-file write enable from the decoder.
- `dec_dram_we`  in  1  data-memory write enable from the decoder.
- `dec_npc_op`  in  1  next-PC select from the decoder (1 = branch/jump target).
- `imem_req`  out  1  instruction fetch request.
- `imem_ack`  in  1  instruction data valid.
- `dmem_req`  out  1  data access request.
- `dmem_we`  out  1  data write strobe, valid while `dmem_req` is high.
- `dmem_ack`  in  1  data access complete.
- `ir_we`  out  1  latch the instruction register.
- `pc_we`  out  1  commit the PC update.
- `npc_sel`  out  1  next-PC select, valid with `pc_we`.
- `rf_we`  out  1  gated register-file write.
- `halted`  out  1  sequencer is in HALT.
- `err_timeout`  out  1  sticky flag: the halt was caused by the watchdog.
- `state`  out  3  current state (debug).
- `instret`  out  32  retired-instruction count (see Configuration).

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7. The state register is clocked.
- Outputs are Moore-decoded from state, except `ir_we`, `pc_we` and `rf_we`. Those are Mealy on ack or state as listed below. All outputs are 0 during any cycle with `rst`=1.
- FETCH:
  - `imem_req`=1.
  - On `imem_ack`: `ir_we`=1 for that cycle only, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: one cycle, for regfile read and sext. Then go to EXEC.
- EXEC: one cycle. The next step depends on `inst_op`:
  - `0000011` (load) or `0100011` (store): go to MEM.
  - `1100011` (branch): `pc_we`=1, `npc_sel`=`dec_npc_op`, go to FETCH.
  - `0110011`, `0010011`, `0110111`, `1101111`, `1100111`: go to WB.
  - Any other opcode: go to HALT.
- MEM:
  - `dmem_req`=1 and `dmem_we`=`dec_dram_we`, held stable until ack.
  - On `dmem_ack` for a store: `pc_we`=1, `npc_sel`=0, go to FETCH.
  - On `dmem_ack` for a load: go to WB.
- WB: `rf_we`=`dec_rf_we`, `pc_we`=1, `npc_sel`=`dec_npc_op`, go to FETCH. This covers jal/jalr redirect.
- HALT:
  - `halted`=1; all strobes and requests are 0.
  - Only `rst` leaves HALT.
- Watchdog:
  - An 8..16-bit wait counter clears on entry to FETCH or MEM and increments each cycle the request is unacked.
  - When the counter reaches `TIMEOUT` without an ack: go to HALT and set `err_timeout`.
  - `err_timeout` stays set until `rst`.
- Acks arriving while the matching request is low are ignored.

## Timing
- The earliest ack is the same cycle the request is high; ack is sampled on the clock edge.
- Cycle counts with zero-wait memory:
  - ALU, lui, jal, jalr: 4 cycles (FETCH, DECODE, EXEC, WB).
  - load: 5 cycles.
  - store: 4 cycles.
  - branch: 3 cycles.
- Each memory wait cycle adds 1 cycle.
- `pc_we` is exactly one cycle per retired instruction. `rf_we` is never high outside WB.
- Reset mid-handshake: the request drops in the `rst` cycle. The first cycle after `rst` falls is FETCH with `imem_req`=1.
- `inst_op` and the `dec_*` inputs are sampled only in EXEC, MEM and WB. They must be stable from DECODE onward because the IR is unchanged after `ir_we`.

## Configuration
- `MC_SEQ_INSTRET_EN` defined: `instret` is a 32-bit counter, reset to 0, incremented on every `pc_we` cycle, wrapping 0xFFFFFFFF→0.
- `MC_SEQ_INSTRET_EN` undefined: `instret` is tied to 0 and no counter is synthesized.

## Test plan
- Reset, then zero-wait `addi` (`inst_op`=`0010011`, `dec_rf_we`=1): states 0→1→2→4→0; `ir_we` in cycle 0; `rf_we`=`pc_we`=1 in cycle 3 only; `instret`=1.
- Load with `dmem_ack` delayed 3 cycles: `dmem_req` high 4 cycles with `dmem_we`=0; WB follows; total 8 cycles; `rf_we` pulses once.
- Store and taken branch:
  - Store with `dec_dram_we`=1: `dmem_we`=1 throughout MEM; `rf_we` never high.
  - Branch with `dec_npc_op`=1: `pc_we`=`npc_sel`=1 in EXEC; 3-cycle instruction.
- `TIMEOUT`=4 with `imem_ack` held 0: HALT after 4 FETCH wait cycles, `halted`=1, `err_timeout`=1; `rst` clears both and restarts FETCH.
- Illegal opcode `0000000`: HALT from EXEC, `err_timeout`=0, no `pc_we`. Separately, `rst` asserted during MEM: `dmem_req` low the same cycle, FETCH the next.
- With `MC_SEQ_INSTRET_EN`: preload the counter path to 0xFFFFFFFF, retire one instruction → `instret`=0. Without the macro: `instret`=0 after 10 instructions.
